// File: rtl/coax_pkg.sv
// Shared types and constants for the coax TX scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a. Defining COAX_TX_PARITY_EN adds an even-parity cell to every word.
package coax_pkg;

  typedef enum logic [2:0] {IDLE, START, WORD, END, GAP} state_t;

  localparam int END_CELLS = 2;
  localparam int DATA_W    = 10;

`ifdef COAX_TX_PARITY_EN
  localparam int W = 12;
`else
  localparam int W = 11;
`endif

  // Wide enough for the longest phase measured in cells (a word).
  localparam int CELL_W = $clog2(W + 1);

  // Cell bits of one word, first-transmitted bit in the MSB.
  function automatic logic [W-1:0] word_cells(input logic [DATA_W-1:0] d);
`ifdef COAX_TX_PARITY_EN
    return {1'b1, d, ^d};
`else
    return {1'b1, d};
`endif
  endfunction

endpackage

// File: rtl/coax_tx_cell_timer.sv
// Bit-cell timer: clock-in-cell and cell-in-phase counters with half/cell/phase strobes.
// Latency: strobes are combinational from the counters; restart zeroes them on the next clock.
// Backpressure: none; counts every clock while restart is low.
module coax_tx_cell_timer
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic [CELL_W-1:0] phase_cells,
  output logic              half_stb,
  output logic              cell_end,
  output logic              phase_end
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0]     clk_cnt;
  logic [CELL_W-1:0] cell_cnt;

  // half_stb marks the last clock of the first half-cell.
  assign half_stb  = (clk_cnt == HALF_LAST);
  assign cell_end  = (clk_cnt == CELL_LAST);
  assign phase_end = cell_end && (cell_cnt == phase_cells - CELL_W'(1));

  // Step through clocks of a cell, then cells of a phase, wrapping at phase end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_cnt  <= '0;
      cell_cnt <= '0;
    end else if (restart) begin
      clk_cnt  <= '0;
      cell_cnt <= '0;
    end else if (cell_end) begin
      clk_cnt  <= '0;
      cell_cnt <= phase_end ? '0 : cell_cnt + CELL_W'(1);
    end else begin
      clk_cnt  <= clk_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/coax_tx_scheduler.sv
// Per-frame arbiter and Manchester framer sharing the coax TX between two word sources.
// Latency: valid sampled in IDLE -> grant/busy/active next clock; all outputs except reqN_ready registered.
// Backpressure: reqN_ready pulses only on load cycles; missing valid there truncates the frame (underrun).
// Build option: COAX_TX_PARITY_EN appends an even-parity cell to each word.
module coax_tx_scheduler
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int START_CELLS    = 2,
  parameter int GAP_CLOCKS     = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [9:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       active,
  output logic       tx,
  output logic [1:0] grant,
  output logic       busy,
  output logic       underrun
);

  localparam int GW = $clog2(GAP_CLOCKS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLOCKS - 1);

  state_t            state, state_d;
  logic              tx_d;
  logic [1:0]        grant_d;
  logic              rr_last1;      // requester 1 owned the previous frame
  logic [W-1:0]      sh_q;          // current word's cells, MSB on the line
  logic              last_q;
  logic [GW-1:0]     gap_cnt;
  logic [CELL_W-1:0] phase_cells;
  logic              half_stb, cell_end, phase_end;
  logic              load_cyc, take, pick1;
  logic              sel_valid, sel_last;
  logic [9:0]        sel_data;

  coax_tx_cell_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .restart    ((state == IDLE) || (state == GAP)),
    .phase_cells(phase_cells),
    .half_stb   (half_stb),
    .cell_end   (cell_end),
    .phase_end  (phase_end)
  );

  // Cell count of the phase currently being timed.
  always_comb begin
    phase_cells = CELL_W'(END_CELLS);
    if (state == START)     phase_cells = CELL_W'(START_CELLS);
    else if (state == WORD) phase_cells = CELL_W'(W);
  end

  // A load cycle closes START or a non-final word; ready depends only on state/counters.
  assign load_cyc   = phase_end && ((state == START) || ((state == WORD) && !last_q));
  assign req0_ready = load_cyc && grant[0];
  assign req1_ready = load_cyc && grant[1];
  assign sel_valid  = grant[1] ? req1_valid : req0_valid;
  assign sel_last   = grant[1] ? req1_last  : req0_last;
  assign sel_data   = grant[1] ? req1_data  : req0_data;
  assign take       = load_cyc && sel_valid;
  assign pick1      = req1_valid && (!req0_valid || !rr_last1);

  // Next state plus the line level for the next clock, so tx can be a plain flop.
  always_comb begin
    state_d = state;
    tx_d    = tx;
    grant_d = grant;
    case (state)
      IDLE: begin
        tx_d = 1'b0;
        if (req0_valid || req1_valid) begin
          state_d = START;
          grant_d = pick1 ? 2'b10 : 2'b01;
        end
      end
      START, WORD: begin
        if (phase_end) begin
          // Sync cell opens low; END is flat high.
          state_d = take ? WORD : END;
          tx_d    = !take;
        end else if (cell_end) begin
          tx_d = (state == WORD) ? !sh_q[W-2] : 1'b0;
        end else if (half_stb) begin
          tx_d = (state == WORD) ? sh_q[W-1] : 1'b1;
        end
      end
      END: begin
        tx_d = 1'b1;
        if (phase_end) begin
          state_d = GAP;
          tx_d    = 1'b0;
          grant_d = 2'b00;
        end
      end
      GAP: begin
        tx_d = 1'b0;
        if (gap_cnt == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registered outputs, round-robin pointer, gap counter and word shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tx       <= 1'b0;
      active   <= 1'b0;
      grant    <= 2'b00;
      busy     <= 1'b0;
      underrun <= 1'b0;
      rr_last1 <= 1'b1;
      sh_q     <= '0;
      last_q   <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_d;
      tx       <= tx_d;
      grant    <= grant_d;
      active   <= (state_d == START) || (state_d == WORD) || (state_d == END);
      busy     <= (state_d != IDLE);
      underrun <= load_cyc && !sel_valid;
      if ((state == END) && phase_end) rr_last1 <= grant[1];
      gap_cnt  <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      if (take) begin
        sh_q   <= word_cells(sel_data);
        last_q <= sel_last;
      end else if ((state == WORD) && cell_end) begin
        sh_q   <= sh_q << 1;
      end
    end
  end

endmodule

// File: tb/tb_coax_tx_scheduler.sv
// Scoreboard bench for coax_tx_scheduler: expected frames are queued at stimulus time,
// a negedge monitor reconstructs each frame from active/tx and checks it.
// Honours COAX_TX_PARITY_EN for the word cell count.
module tb_coax_tx_scheduler;

  localparam int CPB  = 8;
  localparam int STC  = 2;
  localparam int GAPC = 16;
`ifdef COAX_TX_PARITY_EN
  localparam int TW = 12;
`else
  localparam int TW = 11;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] req0_data, req1_data;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic       active, tx, busy, underrun;
  logic [1:0] grant;

  coax_tx_scheduler #(.CLOCKS_PER_BIT(CPB), .START_CELLS(STC), .GAP_CLOCKS(GAPC)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .active(active), .tx(tx), .grant(grant), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   g;
    int           len;
    logic [127:0] pat;
    int           ur;
    int           gap;
  } exp_t;

  exp_t sb[$];
  int   rdq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   bad_rdy = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected frame: START '1' cells, per word sync+data(+parity), two flat-high END cells.
  task automatic push_exp(input logic [1:0] g, input int n, input logic [9:0] w0, input logic [9:0] w1,
                          input logic [9:0] w2, input int ur, input int gap);
    exp_t e;
    logic [9:0] w[3];
    logic [11:0] cb;
    w[0] = w0; w[1] = w1; w[2] = w2;
    e.g = g; e.ur = ur; e.gap = gap; e.pat = '0;
    e.len = CPB * (STC + n * TW + 2);
    for (int s = 0; s < STC; s++) e.pat = {e.pat[125:0], 2'b01};
    for (int i = 0; i < n; i++) begin
      cb = {1'b1, w[i], ^w[i]};
      for (int j = 11; j >= 12 - TW; j--) e.pat = {e.pat[125:0], ~cb[j], cb[j]};
    end
    e.pat = {e.pat[123:0], 4'b1111};
    sb.push_back(e);
  endtask

  task automatic set_req(input int p, input logic v, input logic [9:0] d, input logic l);
    if (p == 0) begin req0_valid = v; req0_data = d; req0_last = l; end
    else        begin req1_valid = v; req1_data = d; req1_last = l; end
  endtask

  // Offer n words on requester p; at word index drop_at valid is withheld for that load cycle.
  task automatic drv(input int p, input int n, input logic [9:0] w0, input logic [9:0] w1,
                     input logic [9:0] w2, input int drop_at);
    logic [9:0] w[3];
    int t;
    logic r;
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < n; i++) begin
      set_req(p, (i != drop_at), w[i], (i == n - 1));
      t = 0;
      do begin
        @(negedge clk);
        r = (p == 0) ? req0_ready : req1_ready;
        t++;
      end while (!r && t < 3000);
      if (!r) begin
        checks++; errors++;
        $display("FAIL drv_timeout: requester %0d word %0d never saw ready", p, i);
        set_req(p, 1'b0, 10'h000, 1'b0);
        return;
      end
      @(posedge clk); #1;
      if (i == drop_at) break;
    end
    set_req(p, 1'b0, 10'h000, 1'b0);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 5000);
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, t);
    end
  endtask

  always @(posedge clk) cyc++;

  // Ready observer: handshake timing and grant-ownership of ready.
  always @(negedge clk) begin
    if (reset_n) begin
      if (req0_ready) rdq.push_back(cyc);
      if (req0_ready && grant !== 2'b01) bad_rdy++;
      if (req1_ready && grant !== 2'b10) bad_rdy++;
    end
  end

  // Frame monitor: sample each half-cell mid-point, count length, underruns and preceding gap.
  bit           in_fr = 0;
  int           k, urc, gapm;
  int           idle_cnt = -1;
  logic         h1;
  logic [127:0] apat;
  logic [1:0]   g0;
  always @(negedge clk) begin
    if (!reset_n) begin
      in_fr = 0;
      idle_cnt = -1;
    end else if (active) begin
      if (!in_fr) begin
        in_fr = 1; k = 0; urc = 0; apat = '0; g0 = grant; gapm = idle_cnt;
      end
      if (k % CPB == CPB / 4) h1 = tx;
      if (k % CPB == 3 * CPB / 4) apat = {apat[125:0], h1, tx};
      if (underrun) urc++;
      k++;
    end else begin
      if (in_fr) begin
        in_fr = 0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: grant %b len %0d with empty scoreboard", g0, k);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("frame_grant", 128'(g0), 128'(e.g));
          chk("frame_len", 128'(k), 128'(e.len));
          chk("frame_cells", apat, e.pat);
          chk("frame_underrun", 128'(urc), 128'(e.ur));
          if (e.gap >= 0) chk("frame_gap", 128'(gapm), 128'(e.gap));
        end
        idle_cnt = 0;
      end
      if (idle_cnt >= 0) idle_cnt++;
    end
  end

  initial begin
    int t;
    reset_n = 1'b0;
    set_req(0, 1'b0, 10'h000, 1'b0);
    set_req(1, 1'b0, 10'h000, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_active", 128'(active), 128'(0));
    chk("rst_tx", 128'(tx), 128'(0));
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_underrun", 128'(underrun), 128'(0));
    chk("rst_ready0", 128'(req0_ready), 128'(0));
    chk("rst_ready1", 128'(req1_ready), 128'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Tie straight after reset: req0 first, req1 after exactly GAP+1 idle clocks.
    push_exp(2'b01, 1, 10'h155, 10'h000, 10'h000, 0, -1);
    push_exp(2'b10, 1, 10'h0F0, 10'h000, 10'h000, 0, GAPC + 1);
    fork
      drv(0, 1, 10'h155, 10'h000, 10'h000, -1);
      drv(1, 1, 10'h0F0, 10'h000, 10'h000, -1);
    join
    wait_idle();

    // One-word frame, with grant/busy/active one clock after valid is sampled.
    push_exp(2'b01, 1, 10'h2AA, 10'h000, 10'h000, 0, -1);
    fork
      drv(0, 1, 10'h2AA, 10'h000, 10'h000, -1);
      begin
        @(posedge clk); #1;
        chk("lat_active", 128'(active), 128'(1));
        chk("lat_grant", 128'(grant), 128'(2'b01));
        chk("lat_busy", 128'(busy), 128'(1));
      end
    join
    wait_idle();

    // Back-to-back req0 frames: no extra arbitration dead time.
    push_exp(2'b01, 1, 10'h3FF, 10'h000, 10'h000, 0, -1);
    push_exp(2'b01, 1, 10'h000, 10'h000, 10'h000, 0, GAPC + 1);
    push_exp(2'b01, 1, 10'h201, 10'h000, 10'h000, 0, GAPC + 1);
    drv(0, 1, 10'h3FF, 10'h000, 10'h000, -1);
    drv(0, 1, 10'h000, 10'h000, 10'h000, -1);
    drv(0, 1, 10'h201, 10'h000, 10'h000, -1);
    wait_idle();

    // Underrun on the second word: frame truncated after word one, one pulse.
    push_exp(2'b10, 1, 10'h1C3, 10'h000, 10'h000, 1, -1);
    drv(1, 2, 10'h1C3, 10'h0AB, 10'h000, 1);
    wait_idle();

    // Backpressure: three words, ready pulses spaced one word apart.
    rdq.delete();
    push_exp(2'b01, 3, 10'h001, 10'h200, 10'h155, 0, -1);
    drv(0, 3, 10'h001, 10'h200, 10'h155, -1);
    wait_idle();
    chk("bp_ready_count", 128'(rdq.size()), 128'(3));
    if (rdq.size() == 3) begin
      chk("bp_spacing1", 128'(rdq[1] - rdq[0]), 128'(TW * CPB));
      chk("bp_spacing2", 128'(rdq[2] - rdq[1]), 128'(TW * CPB));
    end

    // Reset in the middle of word cell 5: everything drops at once, then a clean frame.
    set_req(1, 1'b1, 10'h3C3, 1'b1);
    t = 0;
    do begin @(negedge clk); t++; end while (!active && t < 200);
    if (!active) begin
      checks++; errors++;
      $display("FAIL rstmid_start: active %0b never rose", active);
    end
    repeat (STC * CPB + 5 * CPB + 2) @(negedge clk);
    #2 reset_n = 1'b0;
    set_req(1, 1'b0, 10'h000, 1'b0);
    #1;
    chk("rstmid_active", 128'(active), 128'(0));
    chk("rstmid_tx", 128'(tx), 128'(0));
    chk("rstmid_grant", 128'(grant), 128'(0));
    chk("rstmid_busy", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push_exp(2'b10, 1, 10'h2D4, 10'h000, 10'h000, 0, -1);
    drv(1, 1, 10'h2D4, 10'h000, 10'h000, -1);
    wait_idle();

    t = 0;
    while ((sb.size() != 0 || in_fr) && t < 2000) begin @(negedge clk); t++; end
    chk("sb_drained", 128'(sb.size()), 128'(0));
    chk("ready_ownership", 128'(bad_rdy), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
